// File: rtl/tpum_pkg.sv
// Shared TPUM types and constants: BNN state encoding, pipeline sideband payload
// and the lane popcount helper.
package tpum_pkg;

  localparam int unsigned TPUM_VEC_W   = 1024;
  localparam int unsigned TPUM_NUM_OUT = 32;
  localparam int unsigned TPUM_ACC_W   = 32;
  localparam int unsigned TPUM_LANE_W  = 32;
  localparam int unsigned TPUM_PARTS   = 4;
  localparam int unsigned TPUM_BITS_W  = $clog2(TPUM_VEC_W) + 1;
  localparam int unsigned TPUM_IDX_W   = $clog2(TPUM_NUM_OUT);
  localparam int unsigned TPUM_LCNT_W  = $clog2(TPUM_LANE_W) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    RUN   = 3'b010,
    DRAIN = 3'b100
  } bnn_state_t;

  // Per-beat information that rides alongside the data through the pipe.
  typedef struct packed {
    logic                   last;
    logic                   fin;
    logic [TPUM_IDX_W-1:0]  idx;
    logic [TPUM_BITS_W-1:0] bits;
  } bnn_side_t;

  function automatic logic [TPUM_LCNT_W-1:0] popcount_lane(input logic [TPUM_LANE_W-1:0] v);
    logic [TPUM_LCNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(TPUM_LANE_W); i++) begin
      c = c + TPUM_LCNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/bnn_popcount_tree.sv
// Stages 1-2 of the BNN pipe: masked XNOR with per-lane popcounts, then reduction
// of the lanes into four partial sums. Sideband and valid travel with the data.
module bnn_popcount_tree
  import tpum_pkg::*;
#(
  parameter int unsigned VEC_W  = TPUM_VEC_W,
  parameter int unsigned PART_W = $clog2(VEC_W / TPUM_PARTS) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [VEC_W-1:0]  i_r1,
  input  logic [VEC_W-1:0]  i_r2,
  input  bnn_side_t         i_side,
  output logic              o_valid,
  output logic [PART_W-1:0] o_part [TPUM_PARTS],
  output bnn_side_t         o_side
);

  localparam int unsigned LANES = VEC_W / TPUM_LANE_W;
  localparam int unsigned LPP   = LANES / TPUM_PARTS;

  logic [VEC_W-1:0]       w_mask;
  logic [VEC_W-1:0]       w_match;
  logic [TPUM_LCNT_W-1:0] w_lane_cnt [LANES];
  logic [PART_W-1:0]      w_part     [TPUM_PARTS];

  logic                   r_s1_valid;
  bnn_side_t              r_s1_side;
  logic [TPUM_LCNT_W-1:0] r_lane_cnt [LANES];

  logic                   r_s2_valid;
  bnn_side_t              r_s2_side;
  logic [PART_W-1:0]      r_part     [TPUM_PARTS];

  // Thermometer mask: bit i counts when i < clipped valid_bits.
  for (genvar i = 0; i < VEC_W; i++) begin : g_mask
    assign w_mask[i] = (TPUM_BITS_W'(i) < i_side.bits);
  end

  assign w_match = ~(i_r1 ^ i_r2) & w_mask;

  always_comb begin
    for (int l = 0; l < int'(LANES); l++) begin
      w_lane_cnt[l] = popcount_lane(w_match[l*TPUM_LANE_W +: TPUM_LANE_W]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_side  <= '0;
      for (int l = 0; l < int'(LANES); l++) r_lane_cnt[l] <= '0;
    end else begin
      r_s1_valid <= i_valid;
      if (i_valid) begin
        r_s1_side <= i_side;
        for (int l = 0; l < int'(LANES); l++) r_lane_cnt[l] <= w_lane_cnt[l];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < int'(TPUM_PARTS); p++) begin
      w_part[p] = '0;
      for (int j = 0; j < int'(LPP); j++) begin
        w_part[p] = w_part[p] + PART_W'(r_lane_cnt[p*LPP + j]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_side  <= '0;
      for (int p = 0; p < int'(TPUM_PARTS); p++) r_part[p] <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_side <= r_s1_side;
        for (int p = 0; p < int'(TPUM_PARTS); p++) r_part[p] <= w_part[p];
      end
    end
  end

  assign o_valid = r_s2_valid;
  assign o_side  = r_s2_side;
  assign o_part  = r_part;

endmodule

// File: rtl/bnn_xnor_accum.sv
// BNN XNOR-popcount accumulate stage: sums masked matches across a neuron's chunks
// and writes the signed dot product (2*matches - bits) into one RA slot.
module bnn_xnor_accum
  import tpum_pkg::*;
#(
  parameter int unsigned VEC_W   = TPUM_VEC_W,
  parameter int unsigned ACC_W   = TPUM_ACC_W,
  parameter int unsigned NUM_OUT = TPUM_NUM_OUT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [VEC_W-1:0]           r1_vec,
  input  logic [VEC_W-1:0]           r2_vec,
  input  logic [TPUM_BITS_W-1:0]     valid_bits,
  input  logic                       in_last,
  input  logic                       in_final,
  input  logic [$clog2(NUM_OUT)-1:0] out_idx,
  output logic                       ra_wr_en,
  output logic [$clog2(NUM_OUT)-1:0] ra_wr_idx,
  output logic [ACC_W-1:0]           ra_wr_data,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned IDX_W  = $clog2(NUM_OUT);
  localparam int unsigned PART_W = $clog2(VEC_W / TPUM_PARTS) + 1;
  localparam int unsigned SUM_W  = TPUM_BITS_W;

  bnn_state_t             r_state;
  bnn_state_t             w_state_nxt;
  logic                   r_in_ready;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_accept;
  logic [TPUM_BITS_W-1:0] w_bits;
  bnn_side_t              w_side_in;

  logic                   w_s2_valid;
  bnn_side_t              w_s2_side;
  logic [PART_W-1:0]      w_part [TPUM_PARTS];

  logic [SUM_W-1:0]       w_sum;
  logic [ACC_W-1:0]       w_m_tot;
  logic [ACC_W-1:0]       w_b_tot;
  logic [ACC_W-1:0]       w_dot;

  logic [ACC_W-1:0]       r_acc_m;
  logic [ACC_W-1:0]       r_acc_b;
  logic                   r_wr_en;
  logic [IDX_W-1:0]       r_wr_idx;
  logic [ACC_W-1:0]       r_wr_data;
  logic                   r_emit_fin;

  assign w_accept = in_valid && (r_state == RUN);

  assign w_bits = (valid_bits > TPUM_BITS_W'(VEC_W)) ? TPUM_BITS_W'(VEC_W) : valid_bits;

  // in_final only has meaning on a neuron's last chunk.
  always_comb begin
    w_side_in      = '0;
    w_side_in.last = in_last;
    w_side_in.fin  = in_last && in_final;
    w_side_in.idx  = out_idx;
    w_side_in.bits = w_bits;
  end

  bnn_popcount_tree #(
    .VEC_W  (VEC_W),
    .PART_W (PART_W)
  ) u_tree (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_accept),
    .i_r1    (r1_vec),
    .i_r2    (r2_vec),
    .i_side  (w_side_in),
    .o_valid (w_s2_valid),
    .o_part  (w_part),
    .o_side  (w_s2_side)
  );

  // Stage 3 arithmetic: final lane sum, running totals and the dot product.
  always_comb begin
    w_sum = '0;
    for (int p = 0; p < int'(TPUM_PARTS); p++) begin
      w_sum = w_sum + SUM_W'(w_part[p]);
    end
    w_m_tot = r_acc_m + ACC_W'(w_sum);
    w_b_tot = r_acc_b + ACC_W'(w_s2_side.bits);
    w_dot   = {w_m_tot[ACC_W-2:0], 1'b0} - w_b_tot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_m    <= '0;
      r_acc_b    <= '0;
      r_wr_en    <= 1'b0;
      r_wr_idx   <= '0;
      r_wr_data  <= '0;
      r_emit_fin <= 1'b0;
    end else begin
      r_wr_en    <= w_s2_valid && w_s2_side.last;
      r_emit_fin <= w_s2_valid && w_s2_side.last && w_s2_side.fin;
      if (w_s2_valid && w_s2_side.last) begin
        r_wr_idx  <= w_s2_side.idx;
        r_wr_data <= w_dot;
      end
      if ((r_state == IDLE) && start) begin
        r_acc_m <= '0;
        r_acc_b <= '0;
      end else if (w_s2_valid) begin
        // Clearing on the last chunk lets the next neuron follow with no bubble.
        r_acc_m <= w_s2_side.last ? '0 : w_m_tot;
        r_acc_b <= w_s2_side.last ? '0 : w_b_tot;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_accept && in_last && in_final) w_state_nxt = DRAIN;
      DRAIN:   if (r_emit_fin) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt == RUN);
      r_busy     <= (w_state_nxt != IDLE);
      r_done     <= (r_state == DRAIN) && r_emit_fin;
    end
  end

  assign in_ready   = r_in_ready;
  assign busy       = r_busy;
  assign done       = r_done;
  assign ra_wr_en   = r_wr_en;
  assign ra_wr_idx  = r_wr_idx;
  assign ra_wr_data = r_wr_data;

endmodule
